// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I control FSM.
// Holds state codes, opcode values, immediate-format selects and byte-enable patterns.
package multicycle_ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH    = 5'd0,
        S_DECODE   = 5'd1,
        S_MEM_ADDR = 5'd2,
        S_MEM_RD   = 5'd3,
        S_MEM_WB   = 5'd4,
        S_MEM_WR   = 5'd5,
        S_R_EX     = 5'd6,
        S_I_EX     = 5'd7,
        S_ALU_WB   = 5'd8,
        S_BR_EX    = 5'd9,
        S_JAL_EX   = 5'd10,
        S_JALR_EX  = 5'd11,
        S_JMP_WB   = 5'd12,
        S_UPPER_EX = 5'd13,
        S_LUI_WB   = 5'd14,
        S_AUIPC_WB = 5'd15,
        S_TRAP     = 5'd16
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_U    = 3'b001;
    localparam logic [2:0] IMM_J    = 3'b010;
    localparam logic [2:0] IMM_I    = 3'b011;
    localparam logic [2:0] IMM_B    = 3'b100;
    localparam logic [2:0] IMM_S    = 3'b101;
    localparam logic [2:0] IMM_SH   = 3'b110;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // One-hot instruction class produced by the opcode decoder.
    typedef struct packed {
        logic load;
        logic store;
        logic r_type;
        logic i_alu;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
    } iclass_t;

    // Signed and unsigned variants of a width share the same byte lanes.
    function automatic logic [3:0] be_for(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: be_for = BE_BYTE;
            3'b001, 3'b101: be_for = BE_HALF;
            3'b010:         be_for = BE_WORD;
            default:        be_for = BE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_opdecode.sv
// Combinational opcode/funct3 classifier feeding the DECODE routing.
// Produces a one-hot instruction class and a legality bit.
module multicycle_opdecode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output iclass_t    iclass,
    output logic       legal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        iclass = '0;
        legal  = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                iclass.load = 1'b1;
                legal       = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            OPC_STORE: begin
                iclass.store = 1'b1;
                legal        = funct3 inside {3'b000, 3'b001, 3'b010};
            end
            OPC_OP:     begin iclass.r_type = 1'b1; legal = 1'b1; end
            OPC_OP_IMM: begin iclass.i_alu  = 1'b1; legal = 1'b1; end
            OPC_BRANCH: begin iclass.branch = 1'b1; legal = 1'b1; end
            OPC_JAL:    begin iclass.jal    = 1'b1; legal = 1'b1; end
            OPC_JALR: begin
                iclass.jalr = 1'b1;
                legal       = (funct3 == 3'b000);
            end
            OPC_LUI:    begin iclass.lui    = 1'b1; legal = 1'b1; end
            OPC_AUIPC:  begin iclass.auipc  = 1'b1; legal = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_v2.sv
// Multicycle RV32I main control FSM with memory handshake, illegal-instruction
// trap and retired-instruction counter.
module multicycle_control_v2
    import multicycle_ctrl_pkg::*;
#(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter bit          ENABLE_TRAP   = 1'b1,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 mem_ready,
    output logic                 RegWrite,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 Branch,
    output logic                 Jump,
    output logic                 JALorJALR,
    output logic                 MemtoReg,
    output logic                 ALUSrc1,
    output logic                 ALUSrc2,
    output logic [6:0]           ALUOp,
    output logic [3:0]           BE,
    output logic [2:0]           Concat_control,
    output logic                 illegal,
    output logic                 retire,
    output logic [CNT_WIDTH-1:0] instret,
    output logic [4:0]           state
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t  state_q, state_d;
    iclass_t ic;
    logic    legal;
    logic    ready;

    multicycle_opdecode u_opdecode (
        .opcode (opcode),
        .funct3 (funct3),
        .iclass (ic),
        .legal  (legal)
    );

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign ALUOp = opcode;
    assign state = state_q;

    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (RST) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)         instret <= '0;
        else if (retire) instret <= instret + CNT_ONE;
    end

    always_comb begin
        state_d        = state_q;
        RegWrite       = 1'b0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        IRWrite        = 1'b0;
        PCWrite        = 1'b0;
        Branch         = 1'b0;
        Jump           = 1'b0;
        JALorJALR      = 1'b0;
        MemtoReg       = 1'b0;
        ALUSrc1        = 1'b0;
        ALUSrc2        = 1'b0;
        BE             = BE_NONE;
        Concat_control = IMM_NONE;
        illegal        = 1'b0;
        retire         = 1'b0;
        // Outputs stay quiet while reset is asserted, even though FETCH is a Moore state.
        if (!RST) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = ready;
                    PCWrite = ready;
                    if (ready) state_d = S_DECODE;
                end
                S_DECODE: begin
                    if (!legal)                  state_d = ENABLE_TRAP ? S_TRAP : S_FETCH;
                    else if (ic.load | ic.store) state_d = S_MEM_ADDR;
                    else if (ic.r_type)          state_d = S_R_EX;
                    else if (ic.i_alu)           state_d = S_I_EX;
                    else if (ic.branch)          state_d = S_BR_EX;
                    else if (ic.jal)             state_d = S_JAL_EX;
                    else if (ic.jalr)            state_d = S_JALR_EX;
                    else                         state_d = S_UPPER_EX;
                end
                S_MEM_ADDR: begin
                    ALUSrc2        = 1'b1;
                    Concat_control = ic.store ? IMM_S : IMM_I;
                    state_d        = ic.store ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    BE      = be_for(funct3);
                    if (ready) state_d = S_MEM_WB;
                end
                S_MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_MEM_WR: begin
                    MemWrite = 1'b1;
                    BE       = be_for(funct3);
                    if (ready) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_R_EX: state_d = S_ALU_WB;
                S_I_EX: begin
                    ALUSrc2        = 1'b1;
                    Concat_control = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SH : IMM_I;
                    state_d        = S_ALU_WB;
                end
                S_BR_EX: begin
                    Branch         = 1'b1;
                    Concat_control = IMM_B;
                    retire         = 1'b1;
                    state_d        = S_FETCH;
                end
                S_JAL_EX: begin
                    ALUSrc1        = 1'b1;
                    ALUSrc2        = 1'b1;
                    Jump           = 1'b1;
                    Concat_control = IMM_J;
                    PCWrite        = 1'b1;
                    state_d        = S_JMP_WB;
                end
                S_JALR_EX: begin
                    ALUSrc2        = 1'b1;
                    Jump           = 1'b1;
                    JALorJALR      = 1'b1;
                    Concat_control = IMM_I;
                    PCWrite        = 1'b1;
                    state_d        = S_JMP_WB;
                end
                S_UPPER_EX: begin
                    ALUSrc1        = 1'b1;
                    ALUSrc2        = 1'b1;
                    Concat_control = IMM_U;
                    state_d        = ic.lui ? S_LUI_WB : S_AUIPC_WB;
                end
                S_ALU_WB, S_JMP_WB, S_LUI_WB, S_AUIPC_WB: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_TRAP: illegal = 1'b1;
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: doc/multicycle_control_v2.md
Name: multicycle_control_v2

Overview:
- Parametrised successor to the multicycle RV32I main control FSM.
- Sequences FETCH/DECODE/EX/MEM/WB per instruction and drives the datapath control strobes.
- Adds memory ready/wait handshaking, an illegal-instruction trap state, fully defined outputs in every state, and a retired-instruction counter.
- Sits between the instruction register (opcode/funct3) and the multicycle datapath.

Parameters:
- MEM_HANDSHAKE, 1: 1 = memory states hold until mem_ready; 0 = mem_ready ignored, treated as 1 (single-cycle memory).
- ENABLE_TRAP, 1: 1 = illegal opcode/funct3 enters TRAP; 0 = illegal instruction returns to FETCH as a no-op.
- CNT_WIDTH, 32: width of the instret counter.

Ports:
- CLK in 1: clock, rising edge.
- RST in 1: reset, asynchronous, active-high.
- opcode in 7: instruction[6:0], stable from DECODE onward.
- funct3 in 3: instruction[14:12].
- mem_ready in 1: memory completes the current access this cycle.
- RegWrite, MemRead, MemWrite, IRWrite, PCWrite, Branch, Jump, JALorJALR, MemtoReg, ALUSrc1, ALUSrc2 out 1 each: datapath strobes.
- ALUOp out 7: opcode passthrough.
- BE out 4: byte enables.
- Concat_control out 3: immediate format select.
- illegal out 1: sticky trap flag.
- retire out 1: one-cycle pulse per completed instruction.
- instret out CNT_WIDTH: retired-instruction count.
- state out 5: current state code, for debug.

Behaviour:
- Outputs are a Moore function of state, plus mem_ready gating in the handshake states.
- Every output has an explicit value in every state. Defaults: all strobes 0, BE=0000, Concat_control=000, ALUOp=opcode.
- While RST is high: state=FETCH, all strobes/BE/Concat 0, illegal=0, instret=0, retire=0. Reset mid-instruction aborts it with no retire.
- States (5-bit codes 0..16) and transitions:
  - FETCH(0): MemRead=1; IRWrite=PCWrite=mem_ready. Hold while !mem_ready; then -> DECODE.
  - DECODE(1): no strobes. Routing:
    - load/store -> MEM_ADDR
    - R-type -> R_EX
    - I-ALU -> I_EX
    - branch -> BR_EX
    - JAL -> JAL_EX
    - JALR -> JALR_EX
    - LUI/AUIPC -> UPPER_EX
    - otherwise -> TRAP (or FETCH if ENABLE_TRAP=0)
  - Legality checked in DECODE: load funct3 in {000,001,010,100,101}; store funct3 in {000,001,010}; JALR funct3=000. Anything else counts as illegal.
  - MEM_ADDR(2): ALUSrc2=1; Concat=011 for load, 101 for store. -> MEM_RD (load) or MEM_WR (store).
  - MEM_RD(3): MemRead=1. BE: 000/100->0001, 001/101->0011, 010->1111. Hold while !mem_ready; then -> MEM_WB.
  - MEM_WB(4): RegWrite=1, MemtoReg=1. -> FETCH, retire.
  - MEM_WR(5): MemWrite=1. BE: 000->0001, 001->0011, 010->1111. Hold while !mem_ready; then -> FETCH, retire.
  - R_EX(6): ALUSrc1=0, ALUSrc2=0. -> ALU_WB.
  - I_EX(7): ALUSrc2=1; Concat=110 if funct3 is 001 or 101, else 011. -> ALU_WB.
  - ALU_WB(8): RegWrite=1. -> FETCH, retire.
  - BR_EX(9): Branch=1, Concat=100. -> FETCH, retire.
  - JAL_EX(10): ALUSrc1=1, ALUSrc2=1, Jump=1, JALorJALR=0, Concat=010, PCWrite=1. -> JMP_WB.
  - JALR_EX(11): ALUSrc2=1, Jump=1, JALorJALR=1, Concat=011, PCWrite=1. -> JMP_WB.
  - JMP_WB(12): RegWrite=1, MemtoReg=0; link value is the datapath's latched PC+4. -> FETCH, retire.
  - UPPER_EX(13): ALUSrc1=1, ALUSrc2=1, Concat=001. -> LUI_WB or AUIPC_WB.
  - LUI_WB(14), AUIPC_WB(15): RegWrite=1. -> FETCH, retire.
  - TRAP(16): all strobes 0, illegal=1. Stays in TRAP until RST.
- Undefined state codes (17..31) -> FETCH on the next edge, all strobes 0.
- Write-side strobes never assert outside the states listed above.
- retire is combinational on the final state's exit cycle. A final state that is held (!mem_ready) gives no retire.
- instret increments on each retire and wraps modulo 2^CNT_WIDTH.
- MEM_HANDSHAKE=0 gives fixed CPI: load 5, store 4, ALU 4, branch 3, jump 4, LUI/AUIPC 4.

Decomposition:
- multicycle_ctrl_pkg holds:
  - state enum (5-bit)
  - opcode constants (LUI, AUIPC, OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR)
  - Concat_control codes (IMM_U=001, IMM_J=010, IMM_I=011, IMM_B=100, IMM_S=101, IMM_SH=110)
  - BE constants
- One sub-module: multicycle_opdecode, combinational. Maps opcode/funct3 to a one-hot instruction class plus a legal bit; used by the DECODE routing.

Test Plan:
- RST pulse mid-MEM_RD (opcode 0000011) -> state=0 immediately, all strobes 0, no retire, instret=0.
- LW (funct3 010), MEM_HANDSHAKE=1, mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles, BE=1111 throughout, RegWrite/MemtoReg=1 for exactly 1 cycle, instret +1.
- SB (funct3 000) then SH (001) with mem_ready=1 -> MemWrite one cycle each, BE=0001 then 0011, 4 cycles each.
- JAL then JALR -> PCWrite+Jump in state 10/11, JALorJALR=0 then 1, Concat 010 then 011, RegWrite in JMP_WB.
- ADDI/SLLI/SRAI (funct3 000/001/101) -> Concat 011/110/110, ALUSrc2=1, RegWrite in ALU_WB.
- opcode 1111111 with ENABLE_TRAP=1 -> DECODE then TRAP, illegal=1 held, no strobes. With ENABLE_TRAP=0 -> back to FETCH, no retire.
- CNT_WIDTH=4, 17 NOP-equivalent ADDIs -> instret wraps to 1.
